// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO result registers: fixed-latency mult/div
// with results committed atomically at the end of the busy window.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  opt,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = 5;
  localparam int unsigned DW = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [DW-1:0]   pend_hi_q, pend_hi_d;
  logic [DW-1:0]   pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;

  logic signed [2*DW-1:0] sprod;
  logic        [2*DW-1:0] uprod;
  logic                   div_ovf;
  logic signed [DW-1:0]   s_dvd, s_dvs, s_quo, s_rem;
  logic        [DW-1:0]   u_dvs, u_quo, u_rem;

  // Full-width products and quotients; divisors are forced to 1 for the
  // divide-by-zero and signed-overflow cases so the datapath never traps.
  assign sprod   = $signed({{DW{v1[DW-1]}}, v1}) * $signed({{DW{v2[DW-1]}}, v2});
  assign uprod   = {{DW{1'b0}}, v1} * {{DW{1'b0}}, v2};
  assign div_ovf = (v1 == 32'h8000_0000) && (v2 == 32'hFFFF_FFFF);
  assign s_dvd   = $signed(v1);
  assign s_dvs   = ((v2 == '0) || div_ovf) ? 32'sd1 : $signed(v2);
  assign s_quo   = s_dvd / s_dvs;
  assign s_rem   = s_dvd % s_dvs;
  assign u_dvs   = (v2 == '0) ? 32'd1 : v2;
  assign u_quo   = v1 / u_dvs;
  assign u_rem   = v1 % u_dvs;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (opt)
            3'b000, 3'b001: begin
              {pend_hi_d, pend_lo_d} = (opt == 3'b000) ? $unsigned(sprod) : uprod;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              busy_d    = 1'b1;
              state_d   = BUSY;
            end
            3'b010, 3'b011: begin
              if (opt == 3'b010) begin
                pend_hi_d = $unsigned(s_rem);
                pend_lo_d = $unsigned(s_quo);
              end else begin
                pend_hi_d = u_rem;
                pend_lo_d = u_quo;
              end
              // Divide by zero still occupies the unit but commits nothing.
              pend_wr_d = (v2 != '0);
              cnt_d     = CW'(DIV_CYCLES);
              busy_d    = 1'b1;
              state_d   = BUSY;
            end
            3'b100:  hi_d = v1;
            3'b101:  lo_d = v1;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
